// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage FSM encoding, write-back control
// bit positions and the default data-memory latency.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int WB_REGWRITE         = 1;
  localparam int WB_MEMTOREG         = 0;
  localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
interface mem_stage_if;

  logic [1:0]  wb_ctlout;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic        zero;
  logic [31:0] EX_MEM_NPC;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;

  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic [1:0]  mem_wb_ctl;
  logic [31:0] read_data;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_wb_dst;
  logic        misaligned;

  modport master (
    output wb_ctlout, branch, memread, memwrite, zero, EX_MEM_NPC, alu_result,
           rdata2out, five_bit_muxout,
    input  pcsrc, branch_target, stall, mem_wb_ctl, read_data, mem_alu_result,
           mem_wb_dst, misaligned
  );

  modport slave (
    input  wb_ctlout, branch, memread, memwrite, zero, EX_MEM_NPC, alu_result,
           rdata2out, five_bit_muxout,
    output pcsrc, branch_target, stall, mem_wb_ctl, read_data, mem_alu_result,
           mem_wb_dst, misaligned
  );

endinterface

// File: rtl/data_mem.sv
// Single-port word memory: synchronous write, combinational read.
module data_mem #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, wait-stated data memory access, MEM/WB latch.
// Optional MEM_ALIGN_CHECK_EN suppresses and flags word-misaligned accesses.
//
// state | meaning
// IDLE  | accepting a new instruction; a memory op with wait states stalls here
// WAIT  | access in flight, cnt counts wait cycles; completes when cnt==WAIT_CYCLES
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  ctl_q, ctl_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  dst_q, dst_d;
  logic        mis_q, mis_d;

  logic        mem_op, mis, acc_op, stall_int, we;
  logic [31:0] rdata;

  always_comb begin
    mem_op = bus.memread | bus.memwrite;
`ifdef MEM_ALIGN_CHECK_EN
    mis = mem_op & (bus.alu_result[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    acc_op    = mem_op & ~mis;
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_op && (WAIT_CYCLES > 0)) begin
          stall_int = 1'b1;
          state_d   = WAIT;
          cnt_d     = 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q != WAIT_LAST) begin
          stall_int = 1'b1;
          cnt_d     = cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
    endcase
  end

  // Gating with rst keeps clock edges during reset from committing a store.
  assign we = rst & acc_op & bus.memwrite & ~stall_int;

  data_mem #(.ADDR_BITS(ADDR_BITS)) u_data_mem (
    .clk   (clk),
    .we    (we),
    .addr  (bus.alu_result[ADDR_BITS+1:2]),
    .wdata (bus.rdata2out),
    .rdata (rdata)
  );

  // A stalled edge inserts a bubble so each instruction writes back once.
  always_comb begin
    ctl_d = 2'b00;
    rd_d  = rd_q;
    alu_d = alu_q;
    dst_d = dst_q;
    mis_d = mis_q;
    if (!stall_int) begin
      ctl_d[WB_REGWRITE] = bus.wb_ctlout[WB_REGWRITE] & ~mis;
      ctl_d[WB_MEMTOREG] = bus.wb_ctlout[WB_MEMTOREG] & ~mis;
      rd_d  = rdata;
      alu_d = bus.alu_result;
      dst_d = bus.five_bit_muxout;
      mis_d = mis;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ctl_q   <= 2'b00;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      dst_q   <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      dst_q   <= dst_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.stall          = stall_int & rst;
  assign bus.pcsrc          = bus.branch & bus.zero & ~stall_int & rst;
  assign bus.branch_target  = bus.EX_MEM_NPC;
  assign bus.mem_wb_ctl     = ctl_q;
  assign bus.read_data      = rd_q;
  assign bus.mem_alu_result = alu_q;
  assign bus.mem_wb_dst     = dst_q;
  assign bus.misaligned     = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage (WAIT_CYCLES=2 and =0 instances)
// against an instruction-level memory model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   use0 = 1'b0;

  logic [1:0]  s_wb;
  logic        s_br, s_rd, s_wr, s_zr;
  logic [31:0] s_npc, s_alu, s_wd;
  logic [4:0]  s_dst;

  logic        o_pcsrc, o_stall, o_mis;
  logic [31:0] o_target, o_rd, o_alu;
  logic [1:0]  o_ctl;
  logic [4:0]  o_dst;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mm [2][256];

  mem_stage_if if2 ();
  mem_stage_if if0 ();

  mem_stage #(.ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mem_stage #(.ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  always #5 clk = ~clk;

  always_comb begin
    if2.wb_ctlout       = use0 ? 2'b0  : s_wb;
    if2.branch          = use0 ? 1'b0  : s_br;
    if2.memread         = use0 ? 1'b0  : s_rd;
    if2.memwrite        = use0 ? 1'b0  : s_wr;
    if2.zero            = use0 ? 1'b0  : s_zr;
    if2.EX_MEM_NPC      = use0 ? 32'd0 : s_npc;
    if2.alu_result      = use0 ? 32'd0 : s_alu;
    if2.rdata2out       = use0 ? 32'd0 : s_wd;
    if2.five_bit_muxout = use0 ? 5'd0  : s_dst;
    if0.wb_ctlout       = use0 ? s_wb  : 2'b0;
    if0.branch          = use0 ? s_br  : 1'b0;
    if0.memread         = use0 ? s_rd  : 1'b0;
    if0.memwrite        = use0 ? s_wr  : 1'b0;
    if0.zero            = use0 ? s_zr  : 1'b0;
    if0.EX_MEM_NPC      = use0 ? s_npc : 32'd0;
    if0.alu_result      = use0 ? s_alu : 32'd0;
    if0.rdata2out       = use0 ? s_wd  : 32'd0;
    if0.five_bit_muxout = use0 ? s_dst : 5'd0;
    o_pcsrc  = use0 ? if0.pcsrc          : if2.pcsrc;
    o_stall  = use0 ? if0.stall          : if2.stall;
    o_mis    = use0 ? if0.misaligned     : if2.misaligned;
    o_target = use0 ? if0.branch_target  : if2.branch_target;
    o_rd     = use0 ? if0.read_data      : if2.read_data;
    o_alu    = use0 ? if0.mem_alu_result : if2.mem_alu_result;
    o_ctl    = use0 ? if0.mem_wb_ctl     : if2.mem_wb_ctl;
    o_dst    = use0 ? if0.mem_wb_dst     : if2.mem_wb_dst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One instruction: expected latency and results follow from the wait count,
  // the memory op type and the model memory contents.
  task automatic step_op(input logic rd, input logic wr, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                         input logic br, input logic zr, input logic [31:0] npc);
    int w, n, m;
    logic memop, mis;
    logic [7:0] idx;
    w = use0 ? 0 : 2;
    m = use0 ? 1 : 0;
    memop = rd | wr;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = memop && (alu[1:0] != 2'b00);
`endif
    n = (memop && !mis) ? w : 0;
    idx = alu[9:2];
    s_rd = rd; s_wr = wr; s_wb = wb; s_alu = alu; s_wd = wd; s_dst = dst;
    s_br = br; s_zr = zr; s_npc = npc;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      chk("stall", 32'(o_stall), 32'(c < n));
      chk("pcsrc", 32'(o_pcsrc), 32'(br & zr & (c == n)));
      chk("branch_target", o_target, npc);
      if (c > 0) chk("bubble_ctl", 32'(o_ctl), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("mem_wb_ctl", 32'(o_ctl), mis ? 32'd0 : 32'(wb));
    chk("mem_alu_result", o_alu, alu);
    chk("mem_wb_dst", 32'(o_dst), 32'(dst));
    chk("read_data", o_rd, mm[m][idx]);
    chk("misaligned", 32'(o_mis), 32'(mis));
    if (wr && !mis) mm[m][idx] = wd;
  endtask

  task automatic prefill();
    for (int i = 0; i < 16; i++)
      step_op(1'b0, 1'b1, 2'b00, 32'(i) << 2, $urandom(), 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rand_ops(input int count);
    logic [31:0] r, ra;
    int k;
    for (int i = 0; i < count; i++) begin
      r  = $urandom();
      ra = $urandom();
      k  = $urandom_range(0, 3);
      step_op(k == 1 || k == 3, k >= 2, r[1:0], {ra[31:10], 4'b0, r[5:2], ra[1:0]},
              $urandom(), r[10:6], r[11], r[12], {ra[15:0], r[31:16]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 256; a++) mm[m][a] = 32'd0;

    s_rd = 1'b0; s_wr = 1'b1; s_wb = 2'b11; s_alu = 32'h44; s_wd = 32'h5555_AAAA;
    s_dst = 5'd3; s_br = 1'b1; s_zr = 1'b1; s_npc = 32'h200;
    #12;
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_pcsrc", 32'(o_pcsrc), 32'd0);
    chk("rst_ctl", 32'(o_ctl), 32'd0);
    chk("rst_read_data", o_rd, 32'd0);
    chk("rst_alu", o_alu, 32'd0);
    chk("rst_dst", 32'(o_dst), 32'd0);
    chk("rst_misaligned", 32'(o_mis), 32'd0);
    s_wr = 1'b0; s_br = 1'b0; s_zr = 1'b0;
    #4 rst = 1'b1;

    step_op(1'b0, 1'b0, 2'b10, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b0, 32'd0);
    step_op(1'b0, 1'b1, 2'b00, 32'h40, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'd0);
    step_op(1'b1, 1'b0, 2'b11, 32'h40, 32'd0, 5'd7, 1'b0, 1'b0, 32'd0);
    step_op(1'b0, 1'b0, 2'b00, 32'h8, 32'd0, 5'd1, 1'b0, 1'b0, 32'd0);
    step_op(1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 5'd0, 1'b1, 1'b1, 32'h100);
    step_op(1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 5'd0, 1'b1, 1'b0, 32'h100);
    step_op(1'b1, 1'b1, 2'b10, 32'h40, 32'h0BAD_F00D, 5'd2, 1'b0, 1'b0, 32'd0);
    step_op(1'b0, 1'b1, 2'b00, 32'h80, 32'hCAFE_0080, 5'd0, 1'b0, 1'b0, 32'd0);
    prefill();
    rand_ops(40);

    step_op(1'b0, 1'b0, 2'b10, 32'hABC, 32'd0, 5'd9, 1'b0, 1'b0, 32'd0);
    s_rd = 1'b0; s_wr = 1'b1; s_wb = 2'b00; s_alu = 32'h80; s_wd = 32'h1111_1111;
    s_dst = 5'd3; s_br = 1'b0; s_zr = 1'b0; s_npc = 32'd0;
    @(negedge clk);
    chk("pre_rst_stall", 32'(o_stall), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_ctl", 32'(o_ctl), 32'd0);
    chk("midrst_read_data", o_rd, 32'd0);
    chk("midrst_alu", o_alu, 32'd0);
    chk("midrst_dst", 32'(o_dst), 32'd0);
    chk("midrst_misaligned", 32'(o_mis), 32'd0);
    @(posedge clk);
    #1 s_wr = 1'b0; s_alu = 32'd0;
    #1 rst = 1'b1;
    step_op(1'b1, 1'b0, 2'b11, 32'h80, 32'd0, 5'd4, 1'b0, 1'b0, 32'd0);

    step_op(1'b1, 1'b0, 2'b11, 32'h42, 32'd0, 5'd6, 1'b0, 1'b0, 32'd0);
    step_op(1'b0, 1'b0, 2'b10, 32'h99, 32'd0, 5'd8, 1'b0, 1'b0, 32'd0);
    rand_ops(20);

    use0 = 1'b1;
    step_op(1'b0, 1'b0, 2'b10, 32'h77, 32'd0, 5'd2, 1'b0, 1'b0, 32'd0);
    step_op(1'b0, 1'b1, 2'b00, 32'h20, 32'h5A5A_1234, 5'd0, 1'b0, 1'b0, 32'd0);
    step_op(1'b1, 1'b0, 2'b11, 32'h20, 32'd0, 5'd12, 1'b0, 1'b0, 32'd0);
    prefill();
    rand_ops(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
